// File: rtl/cipher_test_pkg.sv
// rtl/cipher_test_pkg.sv - shared state codes, header layout, debug layout and sizing helper
package cipher_test_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR      = 4'd1,
    ST_LOAD     = 4'd2,
    ST_RST_UUT  = 4'd3,
    ST_WAIT_KEY = 4'd4,
    ST_WAIT_RES = 4'd5,
    ST_CHECK    = 4'd6,
    ST_DONE     = 4'd7
  } state_t;

  localparam int HDR_MODE_BIT = 0;
  localparam int HDR_LAST_BIT = 1;

  // debug = {pass[7:0], fail[7:0], vector_idx[11:0], state[3:0]}
  localparam int DBG_STATE_LSB = 0;
  localparam int DBG_STATE_W   = 4;
  localparam int DBG_IDX_LSB   = 4;
  localparam int DBG_IDX_W     = 12;
  localparam int DBG_FAIL_LSB  = 16;
  localparam int DBG_FAIL_W    = 8;
  localparam int DBG_PASS_LSB  = 24;
  localparam int DBG_PASS_W    = 8;

  function automatic int words_for(input int width, input int word_w);
    return (width + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/vec_word_loader.sv
// rtl/vec_word_loader.sv - assembles N stream words (MSW first) into a W-bit field
module vec_word_loader #(
  parameter  int W      = 64,
  parameter  int WORD_W = 32,
  parameter  int N      = 2,
  localparam int CW     = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [W-1:0]      field,
  output logic [CW-1:0]     count
);

  // Shifting in at the LSB end keeps the low W bits, so excess MSBs of the first word fall off.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      field <= '0;
      count <= '0;
    end else if (load && (count != CW'(N))) begin
      field <= W'({field, word});
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cipher_autotest_ctrl.sv
// rtl/cipher_autotest_ctrl.sv - vector-driven block-cipher UUT test controller
// Optional macro STOP_ON_FAIL_EN: stop at the first failing vector and report its index and block.
module cipher_autotest_ctrl
  import cipher_test_pkg::*;
#(
  parameter int BLOCK_W        = 64,
  parameter int KEY_W          = 80,
  parameter int WORD_W         = 32,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  output logic               rst_uut,
  output logic [BLOCK_W-1:0] block_i_uut,
  output logic [KEY_W-1:0]   key_uut,
  output logic               encdec_uut,
  input  logic [BLOCK_W-1:0] block_o_uut,
  input  logic               end_key_signal_uut,
  input  logic               end_enc_uut,
  input  logic               end_dec_uut,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   pass_count_o,
  output logic [CNT_W-1:0]   fail_count_o,
  output logic [CNT_W-1:0]   timeout_count_o,
  output logic [15:0]        vector_idx_o,
  output logic [31:0]        debug
`ifdef STOP_ON_FAIL_EN
  ,
  output logic [15:0]        first_fail_idx_o,
  output logic [BLOCK_W-1:0] first_fail_block_o
`endif
);

  localparam int KW  = words_for(KEY_W, WORD_W);
  localparam int BW  = words_for(BLOCK_W, WORD_W);
  localparam int KCW = $clog2(KW + 1);
  localparam int BCW = $clog2(BW + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW  = $clog2(RST_CYCLES + 1);

  state_t             state;
  logic               hdr_last;
  logic               is_timeout;
  logic [BLOCK_W-1:0] result;
  logic [BLOCK_W-1:0] exp_block;
  logic [TW-1:0]      wait_cnt;
  logic [RW-1:0]      rst_cnt;
  logic [KCW-1:0]     key_count;
  logic [BCW-1:0]     in_count;
  logic [BCW-1:0]     exp_count;

  logic xfer, hdr_xfer, load_xfer;
  logic key_full, in_full;
  logic key_load, in_load, exp_load, exp_last;
  logic res_event, wait_expired, check_fail;

  assign word_ready_o = (state == ST_HDR) || (state == ST_LOAD);
  assign xfer         = word_valid_i && word_ready_o;
  assign hdr_xfer     = xfer && (state == ST_HDR);
  assign load_xfer    = xfer && (state == ST_LOAD);

  // LOAD words are routed key -> input -> expected by whichever field is still filling.
  assign key_full = (key_count == KCW'(KW));
  assign in_full  = (in_count == BCW'(BW));
  assign key_load = load_xfer && !key_full;
  assign in_load  = load_xfer && key_full && !in_full;
  assign exp_load = load_xfer && key_full && in_full;
  assign exp_last = exp_load && (exp_count == BCW'(BW - 1));

  assign res_event    = encdec_uut ? end_enc_uut : end_dec_uut;
  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign check_fail   = is_timeout || (result != exp_block);

  vec_word_loader #(.W(KEY_W), .WORD_W(WORD_W), .N(KW)) u_key_loader (
    .clk(clk), .rst(rst), .clear(hdr_xfer), .load(key_load), .word(word_i),
    .field(key_uut), .count(key_count)
  );

  vec_word_loader #(.W(BLOCK_W), .WORD_W(WORD_W), .N(BW)) u_in_loader (
    .clk(clk), .rst(rst), .clear(hdr_xfer), .load(in_load), .word(word_i),
    .field(block_i_uut), .count(in_count)
  );

  vec_word_loader #(.W(BLOCK_W), .WORD_W(WORD_W), .N(BW)) u_exp_loader (
    .clk(clk), .rst(rst), .clear(hdr_xfer), .load(exp_load), .word(word_i),
    .field(exp_block), .count(exp_count)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rst_uut         <= 1'b1;
      encdec_uut      <= 1'b0;
      hdr_last        <= 1'b0;
      is_timeout      <= 1'b0;
      result          <= '0;
      wait_cnt        <= '0;
      rst_cnt         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_count_o    <= '0;
      fail_count_o    <= '0;
      timeout_count_o <= '0;
      vector_idx_o    <= '0;
`ifdef STOP_ON_FAIL_EN
      first_fail_idx_o   <= '0;
      first_fail_block_o <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_HDR;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
            rst_uut         <= 1'b0;
            pass_count_o    <= '0;
            fail_count_o    <= '0;
            timeout_count_o <= '0;
            vector_idx_o    <= '0;
`ifdef STOP_ON_FAIL_EN
            first_fail_idx_o   <= '0;
            first_fail_block_o <= '0;
`endif
          end
        end
        ST_HDR: begin
          if (xfer) begin
            encdec_uut <= word_i[HDR_MODE_BIT];
            hdr_last   <= word_i[HDR_LAST_BIT];
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (exp_last) begin
            state   <= ST_RST_UUT;
            rst_uut <= 1'b1;
            rst_cnt <= '0;
          end
        end
        ST_RST_UUT: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state      <= ST_WAIT_KEY;
            rst_uut    <= 1'b0;
            wait_cnt   <= '0;
            is_timeout <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        ST_WAIT_KEY: begin
          if (end_key_signal_uut) begin
            state    <= ST_WAIT_RES;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            state      <= ST_CHECK;
            is_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_WAIT_RES: begin
          // The event wins over a same-cycle expiry.
          if (res_event) begin
            state  <= ST_CHECK;
            result <= block_o_uut;
          end else if (wait_expired) begin
            state      <= ST_CHECK;
            is_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_CHECK: begin
          if (check_fail) fail_count_o <= sat_inc(fail_count_o);
          else            pass_count_o <= sat_inc(pass_count_o);
          if (is_timeout) timeout_count_o <= sat_inc(timeout_count_o);
          vector_idx_o <= vector_idx_o + 16'd1;
`ifdef STOP_ON_FAIL_EN
          if (check_fail) begin
            first_fail_idx_o   <= vector_idx_o;
            first_fail_block_o <= result;
          end
          if (hdr_last || check_fail) begin
`else
          if (hdr_last) begin
`endif
            state   <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            rst_uut <= 1'b1;
          end else begin
            state <= ST_HDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    debug = '0;
    debug[DBG_STATE_LSB +: DBG_STATE_W] = state;
    debug[DBG_IDX_LSB +: DBG_IDX_W]     = vector_idx_o[DBG_IDX_W-1:0];
    debug[DBG_FAIL_LSB +: DBG_FAIL_W]   = fail_count_o[DBG_FAIL_W-1:0];
    debug[DBG_PASS_LSB +: DBG_PASS_W]   = pass_count_o[DBG_PASS_W-1:0];
  end

endmodule

// File: tb/tb_cipher_autotest_ctrl.sv
// tb/tb_cipher_autotest_ctrl.sv - randomized bench with a PRESENT-80 model UUT and a run-level reference model
module tb_cipher_autotest_ctrl;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int WORD_W  = 32;
  localparam int RST_CYC = 3;
  localparam int TMO     = 64;
  localparam int CNT_W   = 16;
  localparam int VEC_WORDS = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WORD_W-1:0]  word_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic               rst_uut;
  logic [BLOCK_W-1:0] block_i_uut;
  logic [KEY_W-1:0]   key_uut;
  logic               encdec_uut;
  logic [BLOCK_W-1:0] block_o_uut;
  logic               end_key_signal_uut;
  logic               end_enc_uut;
  logic               end_dec_uut;
  logic               busy_o;
  logic               done_o;
  logic [CNT_W-1:0]   pass_count_o;
  logic [CNT_W-1:0]   fail_count_o;
  logic [CNT_W-1:0]   timeout_count_o;
  logic [15:0]        vector_idx_o;
  logic [31:0]        debug;
`ifdef STOP_ON_FAIL_EN
  logic [15:0]        first_fail_idx_o;
  logic [BLOCK_W-1:0] first_fail_block_o;
`endif

  cipher_autotest_ctrl #(
    .BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .WORD_W(WORD_W),
    .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .rst_uut(rst_uut), .block_i_uut(block_i_uut), .key_uut(key_uut), .encdec_uut(encdec_uut),
    .block_o_uut(block_o_uut), .end_key_signal_uut(end_key_signal_uut),
    .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut),
    .busy_o(busy_o), .done_o(done_o), .pass_count_o(pass_count_o), .fail_count_o(fail_count_o),
    .timeout_count_o(timeout_count_o), .vector_idx_o(vector_idx_o), .debug(debug)
`ifdef STOP_ON_FAIL_EN
    , .first_fail_idx_o(first_fail_idx_o), .first_fail_block_o(first_fail_block_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // PRESENT-80 reference cipher
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] x);
    for (int j = 0; j < 16; j++) if (sb(4'(j)) == x) return 4'(j);
    return 4'h0;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    for (int i = 0; i < 16; i++) o[i*4 +: 4] = inv ? isb(s[i*4 +: 4]) : sb(s[i*4 +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    int p;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) o[i] = s[p];
      else     o[p] = s[i];
    end
    return o;
  endfunction

  function automatic logic [63:0] present(input logic [63:0] blk, input logic [79:0] key, input logic enc);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    if (enc) begin
      s = blk;
      for (int r = 1; r <= 31; r++) s = p_layer(s_layer(s ^ rk[r], 0), 0);
      s = s ^ rk[32];
    end else begin
      s = blk ^ rk[32];
      for (int r = 31; r >= 1; r--) s = s_layer(p_layer(s, 1), 1) ^ rk[r];
    end
    return s;
  endfunction

  // Stream source with optional random gaps
  logic [31:0] stream_q[$];
  bit gaps = 0;

  initial begin : src
    bit hs;
    word_valid_i = 1'b0;
    word_i = '0;
    forever begin
      @(negedge clk);
      hs = word_valid_i && word_ready_o;
      @(posedge clk);
      if (hs && stream_q.size() > 0) void'(stream_q.pop_front());
      #1;
      if (stream_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        word_valid_i = 1'b1;
        word_i = stream_q[0];
      end else begin
        word_valid_i = 1'b0;
        word_i = $urandom;
      end
    end
  end

  // Behavioural UUT: key done after a delay, then result; can hang or emit a wrong-mode pulse first
  bit uut_hang = 0;
  bit inject_wrong = 0;

  initial begin : uut
    int ph, dly;
    logic [63:0] r;
    end_key_signal_uut = 1'b0; end_enc_uut = 1'b0; end_dec_uut = 1'b0;
    block_o_uut = '0; ph = 2; dly = 0;
    forever begin
      @(posedge clk); #2;
      end_key_signal_uut = 1'b0; end_enc_uut = 1'b0; end_dec_uut = 1'b0;
      r = present(block_i_uut, key_uut, encdec_uut);
      if (rst_uut) begin
        ph = 0; dly = $urandom_range(1, 6);
      end else if (ph == 0) begin
        if (dly > 0) dly--;
        else begin end_key_signal_uut = 1'b1; ph = 1; dly = $urandom_range(1, 8); end
      end else if (ph == 1) begin
        if (dly > 0) begin
          if (inject_wrong && dly == 1) begin
            block_o_uut = ~r;
            if (encdec_uut) end_dec_uut = 1'b1; else end_enc_uut = 1'b1;
          end
          dly--;
        end else if (!uut_hang) begin
          block_o_uut = r;
          if (encdec_uut) end_enc_uut = 1'b1; else end_dec_uut = 1'b1;
          ph = 2;
        end
      end
    end
  end

  // rst_uut pulse width during a run, and WAIT_RES dwell time
  int rst_run = 0, wr_run = 0, wr_last = 0;
  always @(negedge clk) begin
    if (busy_o && rst_uut) rst_run++;
    else begin
      if (busy_o && rst_run > 0) check("rst_uut_pulse_len", rst_run, RST_CYC);
      rst_run = 0;
    end
    if (debug[3:0] == 4'd5) wr_run++;
    else begin
      if (wr_run > 0) wr_last = wr_run;
      wr_run = 0;
    end
  end

  // Run-level reference: per-vector outcome (0 pass, 1 fail, 2 timeout), last flag, true UUT result
  int          vo[$];
  bit          vlast[$];
  logic [63:0] vblk[$];

  task automatic add_vec(input logic mode, input logic last, input logic [79:0] key,
                         input logic [63:0] pt, input logic [63:0] expv);
    logic [95:0] kx;
    logic [31:0] h;
    logic [63:0] truth;
    h = $urandom; h[0] = mode; h[1] = last;
    kx = {16'($urandom), key};
    stream_q.push_back(h);
    stream_q.push_back(kx[95:64]); stream_q.push_back(kx[63:32]); stream_q.push_back(kx[31:0]);
    stream_q.push_back(pt[63:32]); stream_q.push_back(pt[31:0]);
    stream_q.push_back(expv[63:32]); stream_q.push_back(expv[31:0]);
    truth = present(pt, key, mode);
    vo.push_back(uut_hang ? 2 : ((truth == expv) ? 0 : 1));
    vlast.push_back(last);
    vblk.push_back(truth);
  endtask

  task automatic add_rand_vec(input logic mode, input logic last, input bit bad);
    logic [79:0] k;
    logic [63:0] p, e;
    k = {16'($urandom), $urandom, $urandom};
    p = {$urandom, $urandom};
    e = present(p, k, mode);
    if (bad) e[$urandom_range(0, 63)] ^= 1'b1;
    add_vec(mode, last, k, p, e);
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_check(input string tag);
    int p, f, t, idx, ffi;
    logic [63:0] ffb;
    bit ok;
    p = 0; f = 0; t = 0; idx = 0; ffi = -1; ffb = '0;
    for (int i = 0; i < vo.size(); i++) begin
      idx++;
      if (vo[i] == 0) p++;
      else begin f++; if (vo[i] == 2) t++; end
`ifdef STOP_ON_FAIL_EN
      if (vo[i] != 0) begin ffi = i; ffb = vblk[i]; break; end
`endif
      if (vlast[i]) break;
    end
    pulse_start();
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      if (done_o) ok = 1;
      else @(negedge clk);
    end
    check({tag, "_done"}, ok, 1);
    check({tag, "_pass"}, pass_count_o, p);
    check({tag, "_fail"}, fail_count_o, f);
    check({tag, "_timeout"}, timeout_count_o, t);
    check({tag, "_idx"}, vector_idx_o, idx);
    check({tag, "_busy_rst_uut"}, {busy_o, rst_uut}, 2'b01);
    check({tag, "_debug"}, debug, {8'(p), 8'(f), 12'(idx), 4'd7});
    check({tag, "_words_left"}, stream_q.size(), VEC_WORDS * (vo.size() - idx));
`ifdef STOP_ON_FAIL_EN
    if (ffi >= 0) begin
      check({tag, "_first_fail_idx"}, first_fail_idx_o, ffi);
      if (vo[ffi] == 1) check({tag, "_first_fail_block"}, first_fail_block_o, ffb);
    end
`endif
    stream_q.delete(); vo.delete(); vlast.delete(); vblk.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    logic [79:0] k4;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rst_uut", rst_uut, 1);
    check("reset_busy_done_ready", {busy_o, done_o, word_ready_o}, 3'b000);
    check("reset_counts", {pass_count_o, fail_count_o, timeout_count_o, vector_idx_o}, 0);
    check("reset_debug", debug, 0);
    check("reset_uut_drive", {key_uut, block_i_uut, encdec_uut}, 0);

    // 1: PRESENT known answer
    add_vec(1'b1, 1'b1, 80'h0, 64'h0, 64'h5579C1387B228445);
    run_check("t1");
    check("t1_pass_const", pass_count_o, 1);
    check("t1_fail_const", fail_count_o, 0);
    check("t1_key_uut", key_uut, 80'h0);

    // 2: wrong expected value
    add_vec(1'b1, 1'b1, 80'h0, 64'h0, 64'h5579C1387B228446);
    run_check("t2");
    check("t2_fail_const", {pass_count_o, fail_count_o}, {16'd0, 16'd1});
    check("t2_state_done", debug[3:0], 7);

    // 3: UUT never finishes encryption
    uut_hang = 1;
    add_rand_vec(1'b1, 1'b1, 0);
    run_check("t3");
    uut_hang = 0;
    check("t3_wait_res_len", wr_last, TMO);
    check("t3_timeout_const", {fail_count_o, timeout_count_o}, {16'd1, 16'd1});

    // 4: enc, dec, enc with gaps and wrong-mode pulses
    gaps = 1; inject_wrong = 1;
    add_rand_vec(1'b1, 1'b0, 0);
    add_rand_vec(1'b0, 1'b0, 0);
    k4 = {16'($urandom), $urandom, $urandom};
    add_vec(1'b1, 1'b1, k4, 64'h0123456789ABCDEF, present(64'h0123456789ABCDEF, k4, 1'b1));
    run_check("t4");
    inject_wrong = 0;
    check("t4_pass_const", {pass_count_o, vector_idx_o}, {16'd3, 16'd3});
    check("t4_key_uut", key_uut, k4);

    // 5: reset during LOAD, then a clean run
    add_rand_vec(1'b1, 1'b1, 0);
    pulse_start();
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (debug[3:0] == 4'd2 && stream_q.size() <= 6) ok = 1;
      else @(negedge clk);
    end
    check("t5_reached_load", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_uut", rst_uut, 1);
    check("t5_state_counts", {busy_o, done_o, pass_count_o, fail_count_o, vector_idx_o, debug}, 0);
    stream_q.delete(); vo.delete(); vlast.delete(); vblk.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    add_rand_vec(1'b0, 1'b1, 0);
    run_check("t5b");

    // 6: three vectors, middle one bad
    add_rand_vec(1'b1, 1'b0, 0);
    add_rand_vec(1'b1, 1'b0, 1);
    add_rand_vec(1'b0, 1'b1, 0);
    run_check("t6");

    // 7: random runs
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        add_rand_vec(1'($urandom_range(0, 1)), (i == n - 1), ($urandom_range(0, 3) == 0));
      run_check("t7");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
